// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, PC step, fetch FSM states and opcode field.
package if_stage_pkg;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        StReq,
        StDrop,
        StHold
    } fetch_state_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with flush/hold/load controls; flush beats hold, hold beats load.
module ifid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            // Flush yields a NOP bubble; the stale PC is harmless once valid is low.
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!hold_i && load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives a variable-latency imem handshake, feeds IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  redirect_q, redirect_d;
    logic [INSTR_W-1:0] buf_q, buf_d;

    logic [ADDR_W-1:0]  pc_plus4;
    logic               ifid_load, ifid_hold, ifid_flush;
    logic [INSTR_W-1:0] ifid_instr_in;
    logic [ADDR_W-1:0]  ifid_pc_in;

    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_d    = redirect_q;
        buf_d         = buf_q;
        ifid_load     = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_pc_in    = pc_plus4;
        unique case (state_q)
            StReq: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (imem_ready) begin
                        pc_d = branch_addr;
                    end else begin
                        // Outstanding address must stay stable, so redirect after it completes.
                        redirect_d = branch_addr;
                        state_d    = StDrop;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (freeze) begin
                        buf_d     = imem_rdata;
                        ifid_hold = 1'b1;
                        state_d   = StHold;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (freeze) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            StDrop: begin
                ifid_flush = 1'b1;
                if (branch_taken) begin
                    if (imem_ready) begin
                        pc_d    = branch_addr;
                        state_d = StReq;
                    end else begin
                        redirect_d = branch_addr;
                    end
                end else if (imem_ready) begin
                    pc_d    = redirect_q;
                    state_d = StReq;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    pc_d       = branch_addr;
                    state_d    = StReq;
                end else if (freeze) begin
                    ifid_hold = 1'b1;
                end else begin
                    // pc_q already advanced past the buffered instruction.
                    ifid_load     = 1'b1;
                    ifid_instr_in = buf_q;
                    ifid_pc_in    = pc_q;
                    state_d       = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            redirect_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            buf_q      <= buf_d;
        end
    end

    assign imem_req  = !rst && (state_q != StHold);
    assign imem_addr = pc_q;

    ifid_reg #(
        .DATA_W (INSTR_W),
        .PC_W   (ADDR_W)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .instr_i (ifid_instr_in),
        .pc_i    (ifid_pc_in),
        .instr_o (ifid_instr),
        .pc_o    (ifid_pc),
        .valid_o (ifid_valid)
    );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Honours `freeze` from the control/hazard logic (including the two-cycle swap sequence) and branch redirects from EX.
- Presents `ifid_instr`, whose bits [31:26] are the decode stage's opcode, plus `ifid_pc` (PC+4) to decode.

Parameters:
- `ADDR_W`, 32, PC and instruction-memory address width.
- `INSTR_W`, 32, instruction width.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hold PC and IF/ID contents (swap sequencing, hazard stall).
- `branch_taken`  in  1  EX-stage redirect strobe, one cycle.
- `branch_addr`  in  `ADDR_W`  redirect target, valid with `branch_taken`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  `ADDR_W`  fetch address; held stable while `imem_req`=1 until `imem_ready`.
- `imem_rdata`  in  `INSTR_W`  instruction, valid when `imem_ready`=1.
- `imem_ready`  in  1  completes the outstanding request (any latency ≥0 cycles after `imem_req`).
- `ifid_instr`  out  `INSTR_W`  registered instruction to decode; all-zero (NOP) when invalid.
- `ifid_pc`  out  `ADDR_W`  registered fetch address + 4.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (`rst`=1 at an edge):
  - `pc`=`RESET_PC`, state=REQ, `redirect`=0, `buf`=0.
  - `ifid_instr`=0, `ifid_pc`=0, `ifid_valid`=0.
  - `imem_req` is forced 0 while `rst`=1.
  - Reset mid-request abandons it; the memory must tolerate a dropped request.
- States:
  - REQ (`imem_req`=1, `imem_addr`=`pc`).
  - DROP (`imem_req`=1, `imem_addr`=`pc`; the returning data is discarded).
  - HOLD (`imem_req`=0; a fetched instruction waits in `buf`).
- Priority at every edge: `rst` > `branch_taken` > `freeze` > normal.
- REQ:
  - `imem_ready`=0, no branch: stay. `ifid_valid`<=0 and `ifid_instr`<=0 unless `freeze`, which holds IF/ID.
  - `imem_ready`=1, no branch, no freeze: `ifid_instr`<=`imem_rdata`, `ifid_pc`<=`pc`+4, `ifid_valid`<=1, `pc`<=`pc`+4; stay REQ. Zero-bubble, one instruction per cycle.
  - `imem_ready`=1, `freeze`=1: `buf`<=`imem_rdata`, `pc`<=`pc`+4, IF/ID unchanged → HOLD.
  - `branch_taken`, `imem_ready`=1: discard data, `pc`<=`branch_addr`, flush IF/ID (`ifid_valid`<=0, `ifid_instr`<=0); stay REQ.
  - `branch_taken`, `imem_ready`=0: `redirect`<=`branch_addr`, flush IF/ID → DROP. The address is held per protocol.
- DROP:
  - IF/ID stays flushed.
  - On `imem_ready`: discard data, `pc`<=`redirect` → REQ.
  - A further `branch_taken` in DROP overwrites `redirect`; the last one wins.
  - `freeze` is ignored in DROP.
- HOLD:
  - While `freeze`=1: no request, IF/ID held.
  - On `freeze`=0: `ifid_instr`<=`buf`, `ifid_pc`<=`pc` (already +4), `ifid_valid`<=1 → REQ.
  - `branch_taken` in HOLD: discard `buf`, flush IF/ID, `pc`<=`branch_addr` → REQ.
- PC arithmetic is modulo 2^`ADDR_W`; `0xFFFFFFFC`+4 wraps to 0 with no flag.
- `branch_addr` is used as given; no alignment check.
- `freeze` held for N cycles stalls exactly N cycles and loses no instruction or duplicate.

Decomposition:
- Shared package holds:
  - `INSTR_NOP`=0.
  - `PC_STEP`=4.
  - The fetch-state enum {REQ, DROP, HOLD}.
  - `OPCODE_MSB`/`OPCODE_LSB`=31/26, shared with the control unit.
- One natural sub-module: `ifid_reg`.
  - Pipeline register with `load`/`hold`/`flush` controls; flush has priority over load.
  - Reused for later ID/EX-style registers.

Test Plan:
- Reset, `imem_ready`=1 every cycle, `rdata`=`addr`|0xA000_0000 → `ifid_pc`=4,8,12… on consecutive cycles; `ifid_instr`=0xA0000000,0xA0000004…; `ifid_valid`=1 from the first fetch.
- `imem_ready` asserted 3 cycles after `req` → `imem_addr` stable at 0 for 4 cycles, `ifid_valid`=0 until the ready edge, then `ifid_pc`=4.
- `freeze`=1 on the same cycle as ready at pc 8 → HOLD, `imem_req`=0, IF/ID keeps the pc-4 instruction. `freeze` low 2 cycles later → `ifid_pc`=12 next edge; the following request uses `addr` 12.
- `branch_taken`, `branch_addr`=0x40 while the pc-8 request is waiting → DROP. Returning data is not seen on IF/ID (`ifid_instr`=0); next `imem_addr`=0x40; first valid `ifid_pc`=0x44.
- `branch_taken` and `freeze` in the same cycle as ready → branch wins: IF/ID flushed, `pc`=`branch_addr`, state REQ.
- `rst` pulsed during a pending request at pc 0x20 → next cycle `pc`=0, `ifid_valid`=0, `imem_req`=0 during reset, 1 after with `addr` 0.
